atpg_cone_bist: RTL

//  Parametrised successor to the fixed 5-input test cone: wraps a WIDTH-input AND-inhibit cone
//  (out = ~inhibit & ~sel & ~&data) with a built-in self-test engine.

---
 rtl/atpg_cone_bist.sv | 113 +++++++++++
 1 files changed

// File: rtl/atpg_cone_bist.sv
// atpg_cone_bist: registered AND-inhibit cone wrapped with an LFSR/MISR self-test engine
module atpg_cone_bist #(
  parameter int                WIDTH        = 3,
  parameter int                LFSR_W       = 8,
  parameter logic [LFSR_W-1:0] LFSR_POLY    = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED         = 8'h01,
  parameter int                SIG_W        = 16,
  parameter logic [SIG_W-1:0]  MISR_POLY    = 16'h8005,
  parameter int                NUM_PATTERNS = 16,
  parameter logic [SIG_W-1:0]  GOLDEN       = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic             start,
  input  logic             g_inhibit,
  input  logic             g_sel,
  input  logic [WIDTH-1:0] g_data,
  output logic             final_output,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);
  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [SIG_W-1:0]  r_misr;
  logic [CW-1:0]     r_count;
  logic              r_final, r_busy, r_done, r_pass;
  logic              w_r;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [SIG_W-1:0]  w_misr_nxt;
  function automatic logic cone(input logic i, input logic s, input logic [WIDTH-1:0] d);
    return ~i & ~s & ~(&d);
  endfunction
  // Pattern bit 0 drives inhibit, bit 1 select, the next WIDTH bits the AND term
  assign w_r        = cone(r_lfsr[0], r_lfsr[1], r_lfsr[WIDTH+1:2]);
  assign w_lfsr_nxt = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_POLY : '0);
  assign w_misr_nxt = {r_misr[SIG_W-2:0], 1'b0} ^ (r_misr[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(w_r);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= '0;
      r_misr  <= '0;
      r_count <= '0;
      r_final <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!test_mode) r_final <= cone(g_inhibit, g_sel, g_data);
          else if (start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (!test_mode) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lfsr  <= SEED_EFF;
            r_misr  <= '0;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!test_mode) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_final <= w_r;
            r_misr  <= w_misr_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_count <= r_count + 1'b1;
            // Verdict uses the post-update signature so pass is valid with done
            if (r_count == LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_misr_nxt == GOLDEN);
            end
          end
        end
        DONE: begin
          if (test_mode && start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (!test_mode) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign final_output = r_final;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign signature    = r_misr;
endmodule
